// File: rtl/led_pattern_pkg.sv
// Shared mode encoding for the LED pattern engine.
// Codes 6 and 7 are unused and decode as OFF.
package led_pattern_pkg;

   typedef logic [2:0] mode_t;

   localparam mode_t MODE_OFF    = 3'd0;
   localparam mode_t MODE_LEFT   = 3'd1;
   localparam mode_t MODE_RIGHT  = 3'd2;
   localparam mode_t MODE_FLASH  = 3'd3;
   localparam mode_t MODE_BOUNCE = 3'd4;
   localparam mode_t MODE_FILL   = 3'd5;

endpackage

// File: rtl/led_step_div.sv
// Step divider: emits one step_tick every speed+1 enabled cycles.
// A restart clears the count and suppresses the tick for that cycle.
module led_step_div #(
   parameter int DIV_W = 32
) (
   input  logic             clk,
   input  logic             RSTn,
   input  logic             enable,
   input  logic             restart,
   input  logic [DIV_W-1:0] speed,
   output logic             step_tick
);

   logic [DIV_W-1:0] cnt_reg;
   logic [DIV_W-1:0] cnt_next;
   logic             tick;

   // >= rather than == so a speed lowered below the count ends the step at once
   always_comb begin
      cnt_next = cnt_reg;
      tick     = 1'b0;
      if (restart) begin
         cnt_next = '0;
      end else if (enable) begin
         if (cnt_reg >= speed) begin
            tick     = 1'b1;
            cnt_next = '0;
         end else begin
            cnt_next = cnt_reg + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign step_tick = tick & RSTn;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: OFF/LEFT/RIGHT/FLASH/BOUNCE/FILL stepped by a clock-enable tick.
// Optional PWM brightness gating is built when LED_PWM_EN is defined.
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int LED_W = 8,
   parameter int DIV_W = 32,
   parameter int PWM_W = 8
) (
   input  logic             clk,
   input  logic             RSTn,
   input  logic [2:0]       mode,
   input  logic [DIV_W-1:0] speed,
   input  logic             enable,
`ifdef LED_PWM_EN
   input  logic [PWM_W-1:0] brightness,
`endif
   output logic [LED_W-1:0] LED,
   output logic             step_tick
);

   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

   mode_t            mode_reg, mode_next;
   dir_t             dir_reg, dir_next;
   logic [LED_W-1:0] pattern_reg, pattern_next;
   logic [LED_W-1:0] led_reg, led_next;
   logic [LED_W-1:0] shl, shr;
   logic             restart, one_hot, all_ones, fill_ok, move_up;

   if (LED_W < 2 || LED_W > 32 || PWM_W < 1) begin : g_param_out_of_range
   end

   function automatic logic [LED_W-1:0] start_pattern(input mode_t m);
      logic [LED_W-1:0] p;
      p = '0;
      case (m)
         MODE_LEFT, MODE_BOUNCE: p = LED_W'(1);
         MODE_RIGHT:             p = {1'b1, {(LED_W-1){1'b0}}};
         default:                p = '0;
      endcase
      return p;
   endfunction

   assign restart  = (mode != mode_reg);
   assign one_hot  = (pattern_reg != '0) && ((pattern_reg & (pattern_reg - LED_W'(1))) == '0);
   assign all_ones = &pattern_reg;
   // Legal fill patterns are a contiguous run of ones starting at bit 0
   assign fill_ok  = ((pattern_reg & (pattern_reg + LED_W'(1))) == '0);
   assign shl      = pattern_reg << 1;
   assign shr      = pattern_reg >> 1;
   assign move_up  = (dir_reg == DIR_UP) ? !pattern_reg[LED_W-1] : pattern_reg[0];

   led_step_div #(.DIV_W(DIV_W)) u_div (
      .clk       (clk),
      .RSTn      (RSTn),
      .enable    (enable),
      .restart   (restart),
      .speed     (speed),
      .step_tick (step_tick)
   );

   always_comb begin
      mode_next    = mode_reg;
      dir_next     = dir_reg;
      pattern_next = pattern_reg;
      if (restart) begin
         mode_next    = mode;
         dir_next     = DIR_UP;
         pattern_next = start_pattern(mode);
      end else if (step_tick) begin
         case (mode_reg)
            MODE_LEFT:
               pattern_next = one_hot ? {pattern_reg[LED_W-2:0], pattern_reg[LED_W-1]}
                                      : start_pattern(MODE_LEFT);
            MODE_RIGHT:
               pattern_next = one_hot ? {pattern_reg[0], pattern_reg[LED_W-1:1]}
                                      : start_pattern(MODE_RIGHT);
            MODE_FLASH:
               pattern_next = (pattern_reg == '0) ? '1 : '0;
            MODE_BOUNCE: begin
               // Direction flips on arrival at an end so each end is lit for one step only
               if (!one_hot) begin
                  pattern_next = start_pattern(MODE_BOUNCE);
                  dir_next     = DIR_UP;
               end else if (move_up) begin
                  pattern_next = shl;
                  dir_next     = shl[LED_W-1] ? DIR_DOWN : DIR_UP;
               end else begin
                  pattern_next = shr;
                  dir_next     = shr[0] ? DIR_UP : DIR_DOWN;
               end
            end
            MODE_FILL: begin
               if (all_ones || !fill_ok) begin
                  pattern_next = '0;
               end else begin
                  pattern_next = {pattern_reg[LED_W-2:0], 1'b1};
               end
            end
            default:
               pattern_next = '0;
         endcase
      end
   end

`ifdef LED_PWM_EN
   logic [PWM_W-1:0] pwm_cnt_reg;
   logic             pwm_on;

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         pwm_cnt_reg <= '0;
      end else begin
         pwm_cnt_reg <= pwm_cnt_reg + PWM_W'(1);
      end
   end

   assign pwm_on   = (pwm_cnt_reg < brightness);
   assign led_next = pattern_next & {LED_W{pwm_on}};
`else
   assign led_next = pattern_next;
`endif

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         mode_reg    <= MODE_OFF;
         dir_reg     <= DIR_UP;
         pattern_reg <= '0;
         led_reg     <= '0;
      end else begin
         mode_reg    <= mode_next;
         dir_reg     <= dir_next;
         pattern_reg <= pattern_next;
         led_reg     <= led_next;
      end
   end

   assign LED = led_reg;

endmodule
